// File: rtl/tm_mem_pkg.sv
// Shared definitions for the block-index bank: stream FSM states and
// elaboration-time sizing helpers.
package tm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } stream_state_e;

    // SPI words (32 bits each) needed to hold one entry
    function automatic int calc_wpe(input int n_bits);
        return (n_bits + 31) / 32;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_block_idx_fifo2.sv
// Two-entry output FIFO carrying entry data plus its last-beat flag.
module mem_block_idx_fifo2 #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_data [2];
    logic [1:0]    r_last;
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= i_data;
            r_last[r_wptr] <= i_last;
        end
    end

    assign o_data  = r_data[r_rptr];
    assign o_last  = r_last[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/mem_block_idx_stream.sv
// Block-index bank: SPI writes assemble multi-word entries; an autonomous
// reader streams a wrapping address range out through a valid/ready FIFO.
module mem_block_idx_stream
    import tm_mem_pkg::*;
#(
    parameter int N_PE_CLUSTER     = 20,
    parameter int DEPTH_BLOCK_BANK = 2048,
    parameter int SPI_AW           = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                spi_wen_block_bank_sync,
    input  logic [SPI_AW-1:0]                   SPI_ADDR,
    input  logic [31:0]                         SPI_DATA,
    input  logic                                stream_start,
    input  logic [$clog2(DEPTH_BLOCK_BANK)-1:0] stream_base,
    input  logic [$clog2(DEPTH_BLOCK_BANK):0]   stream_len,
    input  logic                                stream_abort,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N_PE_CLUSTER-1:0]             out_data,
    output logic                                out_last,
    output logic                                stream_busy,
    output logic                                stream_done
);

    localparam int WPE    = calc_wpe(N_PE_CLUSTER);
    localparam int AW     = addr_width(DEPTH_BLOCK_BANK);
    localparam int LW     = AW + 1;
    localparam int FULL_W = WPE * 32;
    localparam int STG_W  = (WPE > 1) ? (WPE - 1) * 32 : 32;

    logic [N_PE_CLUSTER-1:0] r_mem [DEPTH_BLOCK_BANK];
    logic [31:0]             w_addr32;
    logic [31:0]             w_entry32;
    logic [31:0]             w_word32;
    logic                    w_in_range;
    logic                    w_commit;
    logic                    w_stage;
    logic [FULL_W-1:0]       w_commit_full;
    logic [N_PE_CLUSTER-1:0] w_commit_data;

    assign w_addr32   = 32'(SPI_ADDR);
    assign w_entry32  = w_addr32 / 32'(WPE);
    assign w_word32   = w_addr32 % 32'(WPE);
    assign w_in_range = w_entry32 < 32'(DEPTH_BLOCK_BANK);
    assign w_commit   = spi_wen_block_bank_sync && w_in_range && (w_word32 == 32'(WPE - 1));
    assign w_stage    = spi_wen_block_bank_sync && w_in_range && (w_word32 != 32'(WPE - 1));

    if (WPE == 1) begin : g_direct
        assign w_commit_full = SPI_DATA;
    end else begin : g_multi
        logic [STG_W-1:0] r_stg;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stg <= '0;
            end else if (w_stage) begin
                r_stg[w_word32*32 +: 32] <= SPI_DATA;
            end
        end
        assign w_commit_full = {SPI_DATA, r_stg};
    end

    assign w_commit_data = w_commit_full[N_PE_CLUSTER-1:0];

    stream_state_e           r_state;
    stream_state_e           w_state_nxt;
    logic [AW-1:0]           r_addr;
    logic [LW-1:0]           r_len;
    logic [LW-1:0]           r_issued;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_flush;
    logic                    w_done_nxt;
    logic [1:0]              w_fifo_count;
    logic                    w_fifo_valid;
    logic                    w_pop;
    logic [N_PE_CLUSTER-1:0] w_head;
    logic                    w_head_last;
    logic [N_PE_CLUSTER-1:0] w_rd_data;

    assign w_fifo_valid = (w_fifo_count != 2'd0);
    assign w_pop        = w_fifo_valid && out_ready;
    assign w_issue_last = (r_issued + LW'(1) == r_len);

    // The FIFO slot is the read data register, so a read is only in flight
    // during its issue cycle; a commit steals the single array port.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (stream_start && !stream_abort) begin
                    if (stream_len != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = STREAM;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (stream_abort) begin
                    w_flush     = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_commit && (w_fifo_count != 2'd2)) begin
                    w_issue = 1'b1;
                    if (w_issue_last) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (stream_abort) begin
                    w_flush     = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr   <= stream_base;
            r_len    <= stream_len;
            r_issued <= '0;
        end else if (w_issue) begin
            r_addr   <= r_addr + AW'(1);
            r_issued <= r_issued + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) r_mem[w_entry32[AW-1:0]] <= w_commit_data;
    end

    assign w_rd_data = r_mem[r_addr];

    mem_block_idx_fifo2 #(
        .DW(N_PE_CLUSTER)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_issue),
        .i_data  (w_rd_data),
        .i_last  (w_issue_last),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_last  (w_head_last),
        .o_count (w_fifo_count)
    );

    assign out_valid   = w_fifo_valid;
    assign out_data    = w_fifo_valid ? w_head : '0;
    assign out_last    = w_fifo_valid && w_head_last;
    assign stream_busy = (r_state != IDLE);
    assign stream_done = r_done;

endmodule

// File: tb/tb_mem_block_idx_stream.sv
// Directed bench: one N=20 (single-word) and one N=40 (two-word) instance.
module tb_mem_block_idx_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_wen;
    logic [11:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_start;
    logic [10:0] a_base;
    logic [11:0] a_len;
    logic        a_abort;
    logic        a_ready;
    logic        a_valid;
    logic [19:0] a_data;
    logic        a_last;
    logic        a_busy;
    logic        a_done;

    logic        b_wen;
    logic [11:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_start;
    logic [10:0] b_base;
    logic [11:0] b_len;
    logic        b_abort;
    logic        b_ready;
    logic        b_valid;
    logic [39:0] b_data;
    logic        b_last;
    logic        b_busy;
    logic        b_done;

    mem_block_idx_stream #(.N_PE_CLUSTER(20), .DEPTH_BLOCK_BANK(2048), .SPI_AW(12)) dut_a (
        .clk(clk), .rst(rst), .spi_wen_block_bank_sync(a_wen), .SPI_ADDR(a_addr),
        .SPI_DATA(a_wdata), .stream_start(a_start), .stream_base(a_base),
        .stream_len(a_len), .stream_abort(a_abort), .out_valid(a_valid),
        .out_ready(a_ready), .out_data(a_data), .out_last(a_last),
        .stream_busy(a_busy), .stream_done(a_done)
    );

    mem_block_idx_stream #(.N_PE_CLUSTER(40), .DEPTH_BLOCK_BANK(2048), .SPI_AW(12)) dut_b (
        .clk(clk), .rst(rst), .spi_wen_block_bank_sync(b_wen), .SPI_ADDR(b_addr),
        .SPI_DATA(b_wdata), .stream_start(b_start), .stream_base(b_base),
        .stream_len(b_len), .stream_abort(b_abort), .out_valid(b_valid),
        .out_ready(b_ready), .out_data(b_data), .out_last(b_last),
        .stream_busy(b_busy), .stream_done(b_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [19:0] cap_data [$];
    logic        cap_last [$];
    int          cap_first;
    int          cap_done;
    int          cap_stall_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_write_a(input logic [11:0] addr, input logic [31:0] data);
        a_wen = 1'b1; a_addr = addr; a_wdata = data;
        tick();
        a_wen = 1'b0;
    endtask

    task automatic spi_write_b(input logic [11:0] addr, input logic [31:0] data);
        b_wen = 1'b1; b_addr = addr; b_wdata = data;
        tick();
        b_wen = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,0 repeating; 2: ready high plus SPI commits in cycles 2..4
    task automatic run_a(input logic [10:0] base, input logic [11:0] len, input int mode);
        logic        prev_stall;
        logic [19:0] prev_data;
        cap_data.delete();
        cap_last.delete();
        cap_first = -1; cap_done = -1; cap_stall_err = 0;
        prev_stall = 1'b0; prev_data = '0;
        a_base = base; a_len = len; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            a_ready = (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'b1;
            if (mode == 2 && cyc >= 2 && cyc <= 4) begin
                a_wen = 1'b1; a_addr = 12'(100 + cyc); a_wdata = 32'h000C0000 + 32'(cyc);
            end else begin
                a_wen = 1'b0;
            end
            if (prev_stall && (!a_valid || a_data !== prev_data)) cap_stall_err++;
            if (a_valid && a_ready) begin
                if (cap_first < 0) cap_first = cyc;
                cap_data.push_back(a_data);
                cap_last.push_back(a_last);
            end
            prev_stall = a_valid && !a_ready;
            prev_data  = a_data;
            if (a_done) begin
                cap_done = cyc;
                break;
            end
            tick();
        end
        a_wen = 1'b0;
        a_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_total++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid); else n_pass++;
        n_total++; if (a_data !== 20'h0) $display("FAIL reset_data: got %h want 0", a_data); else n_pass++;
        n_total++; if ({a_last, a_busy, a_done} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {a_last, a_busy, a_done}); else n_pass++;
        n_total++; if ({b_valid, b_last, b_busy, b_done} !== 4'b0000) $display("FAIL reset_b: got %b want 0000", {b_valid, b_last, b_busy, b_done}); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_stream();
        logic [19:0] exp [8];
        exp = '{20'h1, 20'h2, 20'h4, 20'h8, 20'h10, 20'h20, 20'h40, 20'h80};
        for (int i = 0; i < 8; i++) spi_write_a(12'(i), 32'(exp[i]));
        spi_write_a(12'd2048, 32'h000FFFFF);
        run_a(11'd0, 12'd4, 0);
        n_total++; if (cap_data.size() != 4) $display("FAIL basic_count: got %0d want 4", cap_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (cap_data.size() > i && cap_data[i] === exp[i] && cap_last[i] === (i == 3)) n_pass++;
            else $display("FAIL basic_beat%0d: got %h want %h", i, (cap_data.size() > i) ? cap_data[i] : 20'hx, exp[i]);
        end
        n_total++; if (cap_first != 2) $display("FAIL basic_latency: got %0d want 2", cap_first); else n_pass++;
        n_total++; if (cap_done != 6) $display("FAIL basic_done_cycle: got %0d want 6", cap_done); else n_pass++;
        tick();
        n_total++; if ({a_done, a_busy} !== 2'b00) $display("FAIL basic_done_pulse: got %b want 00", {a_done, a_busy}); else n_pass++;
    endtask

    task automatic test_multiword();
        spi_write_b(12'd10, 32'hDEADBEEF);
        spi_write_b(12'd11, 32'h000000A5);
        b_base = 11'd5; b_len = 12'd1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n_total++; if ({b_valid, b_busy} !== 2'b01) $display("FAIL mw_cycle1: got %b want 01", {b_valid, b_busy}); else n_pass++;
        tick();
        n_total++; if (b_valid !== 1'b1 || b_data !== 40'hA5DEADBEEF) $display("FAIL mw_data: got %b/%h want 1/a5deadbeef", b_valid, b_data); else n_pass++;
        n_total++; if (b_last !== 1'b1) $display("FAIL mw_last: got %b want 1", b_last); else n_pass++;
        tick();
        n_total++; if ({b_done, b_valid} !== 2'b10) $display("FAIL mw_done: got %b want 10", {b_done, b_valid}); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        logic [19:0] exp [4];
        exp = '{20'h11111, 20'h22222, 20'h1, 20'h2};
        spi_write_a(12'd2046, 32'h00011111);
        spi_write_a(12'd2047, 32'h00022222);
        run_a(11'd2046, 12'd4, 0);
        n_total++; if (cap_data.size() != 4) $display("FAIL wrap_count: got %0d want 4", cap_data.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (cap_data.size() > i && cap_data[i] === exp[i] && cap_last[i] === (i == 3)) n_pass++;
            else $display("FAIL wrap_beat%0d: got %h want %h", i, (cap_data.size() > i) ? cap_data[i] : 20'hx, exp[i]);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [19:0] exp [6];
        exp = '{20'h1, 20'h2, 20'h4, 20'h8, 20'h10, 20'h20};
        run_a(11'd0, 12'd6, 1);
        n_total++; if (cap_data.size() != 6) $display("FAIL bp_count: got %0d want 6", cap_data.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (cap_data.size() > i && cap_data[i] === exp[i] && cap_last[i] === (i == 5)) n_pass++;
            else $display("FAIL bp_beat%0d: got %h want %h", i, (cap_data.size() > i) ? cap_data[i] : 20'hx, exp[i]);
        end
        n_total++; if (cap_stall_err != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", cap_stall_err); else n_pass++;
        n_total++; if (cap_done < 0) $display("FAIL bp_done: got timeout want done pulse"); else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        logic [19:0] exp [8];
        exp = '{20'h1, 20'h2, 20'h4, 20'h8, 20'h10, 20'h20, 20'h40, 20'h80};
        run_a(11'd0, 12'd8, 2);
        n_total++; if (cap_data.size() != 8) $display("FAIL cont_count: got %0d want 8", cap_data.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (cap_data.size() > i && cap_data[i] === exp[i] && cap_last[i] === (i == 7)) n_pass++;
            else $display("FAIL cont_beat%0d: got %h want %h", i, (cap_data.size() > i) ? cap_data[i] : 20'hx, exp[i]);
        end
        n_total++; if (cap_done != 13) $display("FAIL cont_done_cycle: got %0d want 13", cap_done); else n_pass++;
        tick();
        run_a(11'd102, 12'd3, 0);
        n_total++;
        if (cap_data.size() == 3 && cap_data[0] === 20'hC0002 && cap_data[1] === 20'hC0003 && cap_data[2] === 20'hC0004) n_pass++;
        else $display("FAIL cont_writes: got %0d beats first %h want c0002,c0003,c0004", cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 20'hx);
        tick();
    endtask

    task automatic test_len0();
        a_base = 11'd0; a_len = 12'd0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n_total++; if ({a_done, a_busy, a_valid} !== 3'b100) $display("FAIL len0_done: got %b want 100", {a_done, a_busy, a_valid}); else n_pass++;
        tick();
        n_total++; if ({a_done, a_busy, a_valid} !== 3'b000) $display("FAIL len0_after: got %b want 000", {a_done, a_busy, a_valid}); else n_pass++;
    endtask

    task automatic test_abort();
        int seen_valid;
        a_base = 11'd0; a_len = 12'd8; a_start = 1'b1; a_ready = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        n_total++; if (a_valid !== 1'b1 || a_data !== 20'h1) $display("FAIL abort_beat0: got %b/%h want 1/00001", a_valid, a_data); else n_pass++;
        tick();
        n_total++; if (a_valid !== 1'b1 || a_data !== 20'h2) $display("FAIL abort_beat1: got %b/%h want 1/00002", a_valid, a_data); else n_pass++;
        tick();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        n_total++; if ({a_busy, a_done, a_valid} !== 3'b010) $display("FAIL abort_next: got %b want 010", {a_busy, a_done, a_valid}); else n_pass++;
        seen_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_valid || a_done) seen_valid++;
        end
        n_total++; if (seen_valid != 0) $display("FAIL abort_quiet: got %0d active cycles want 0", seen_valid); else n_pass++;
        a_base = 11'd0; a_len = 12'd4; a_start = 1'b1; a_abort = 1'b1;
        tick();
        a_start = 1'b0; a_abort = 1'b0;
        n_total++; if ({a_busy, a_done} !== 2'b00) $display("FAIL abort_start_idle: got %b want 00", {a_busy, a_done}); else n_pass++;
        tick();
        n_total++; if (a_valid !== 1'b0) $display("FAIL abort_start_valid: got %b want 0", a_valid); else n_pass++;
    endtask

    task automatic test_rst_mid();
        spi_write_b(12'd20, 32'h12345678);
        a_base = 11'd0; a_len = 12'd8; a_start = 1'b1; a_ready = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick();
        n_total++; if (a_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", a_valid); else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if ({a_valid, a_last, a_busy, a_done} !== 4'b0000 || a_data !== 20'h0)
            $display("FAIL rst_mid_outputs: got %b/%h want 0000/00000", {a_valid, a_last, a_busy, a_done}, a_data);
        else n_pass++;
        rst = 1'b0;
        tick();
        spi_write_b(12'd21, 32'h00000007);
        b_base = 11'd10; b_len = 12'd1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        n_total++; if (b_valid !== 1'b1 || b_data !== 40'h0700000000) $display("FAIL rst_staging: got %b/%h want 1/0700000000", b_valid, b_data); else n_pass++;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_wen = 1'b0; a_addr = '0; a_wdata = '0; a_start = 1'b0; a_base = '0; a_len = '0; a_abort = 1'b0; a_ready = 1'b1;
        b_wen = 1'b0; b_addr = '0; b_wdata = '0; b_start = 1'b0; b_base = '0; b_len = '0; b_abort = 1'b0; b_ready = 1'b1;
        test_reset();
        test_write_stream();
        test_multiword();
        test_wrap();
        test_back_pressure();
        test_contention();
        test_len0();
        test_abort();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_block_idx_stream.md
Name: mem_block_idx_stream

Overview:
- Parametrised successor to the single-port block-index bank.
- Stores per-block PE-cluster index masks, with widths allowed to exceed 32 bits; SPI writes assemble multi-word entries.
- Replaces the raw read strobe with an autonomous streaming reader: base, length, wrap-around, valid/ready back-pressure.
- Sits between the SPI slave sync logic and the TM scheduler that dispatches blocks to PE clusters.

Parameters:
- N_PE_CLUSTER, 20, entry width in bits (1..128).
- DEPTH_BLOCK_BANK, 2048, number of entries; must be a power of 2.
- SPI_AW, 12, SPI address width; must satisfy 2^SPI_AW >= DEPTH_BLOCK_BANK*WPE.
- WPE (localparam), ceil(N_PE_CLUSTER/32), SPI words per entry.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_wen_block_bank_sync  in  1  one-cycle write strobe, already synchronised to clk.
- SPI_ADDR  in  SPI_AW  word address: entry = SPI_ADDR / WPE, word = SPI_ADDR % WPE.
- SPI_DATA  in  32  write data.
- stream_start  in  1  pulse; starts a stream.
- stream_base  in  clog2(DEPTH)  first entry address.
- stream_len  in  clog2(DEPTH)+1  entries to read, 0..DEPTH.
- stream_abort  in  1  pulse; cancels the active stream.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_data  out  N_PE_CLUSTER  entry data.
- out_last  out  1  marks the final beat of the stream.
- stream_busy  out  1  high from start acceptance until done.
- stream_done  out  1  one-cycle completion pulse (also on abort).

Behaviour:
- Reset: out_valid=0, out_last=0, out_data=0, stream_busy=0, stream_done=0, FSM=IDLE, staging=0, buffer empty. Memory contents are not reset.
- Write path:
  - Word k<WPE-1 goes into staging register slice k.
  - Word WPE-1 commits {SPI_DATA, staging} truncated to N_PE_CLUSTER bits into the entry in the same cycle.
  - With WPE=1, every strobe commits directly.
  - Addresses with entry >= DEPTH are ignored.
- Port arbitration: single-port array; a commit has priority, and no read issues in a commit cycle.
- Read latency: 1 cycle, array read to data register.
- Output buffer: 2-entry FIFO.
  - Read issue requires (fifo_count + inflight) < 2, so no entry is ever dropped.
  - Output is FIFO head; a beat transfers when out_valid && out_ready.
- FSM IDLE:
  - stream_start with len>0: latch base/len, busy=1, go to STREAM.
  - stream_start with len=0: stream_done pulses in the next cycle and busy stays 0.
- FSM STREAM:
  - Issue one read per eligible cycle; the address increments modulo DEPTH, so base=DEPTH-1 wraps to 0.
  - Go to DRAIN when issued==len.
- FSM DRAIN: when the FIFO is empty and nothing is in flight, go to IDLE with busy=0 and stream_done=1 for one cycle.
- stream_start while busy is ignored.
- Minimum latency: start accepted in cycle 0, first read in cycle 1, out_valid in cycle 2 with no write contention. Sustained throughput is 1 entry/cycle with out_ready held high.
- out_last is set on the beat whose index == len-1.
- stream_abort in STREAM or DRAIN: flush the FIFO, drop the in-flight read, busy goes low and stream_done pulses in the next cycle, FSM returns to IDLE. Abort in IDLE has no effect.
- Simultaneous stream_abort and stream_start: abort wins, start is ignored.
- Writes to an address inside the active stream are allowed; the read returns the old or new value depending on cycle order, with no hazard logic.
- rst mid-stream or mid-assembly: everything returns to reset state and partially assembled staging words are discarded.

Decomposition:
- Package tm_mem_pkg holds:
  - the WPE calculation function;
  - the stream FSM state enum (IDLE, STREAM, DRAIN);
  - the address-width helper.
- One sub-module, mem_block_idx_fifo2: a 2-entry FIFO carrying data and last, with a count output and flush.

Test Plan:
- Write path, N=20, WPE=1: write entries 0..3 = 0x1, 0x2, 0x4, 0x8, then stream base=0 len=4 with ready=1. Expect 4 beats 0x1,0x2,0x4,0x8 in consecutive cycles, first out_valid 2 cycles after start, out_last on beat 3, done pulse after it.
- Multi-word entries, N=40, WPE=2: SPI_ADDR=10 data 0xDEADBEEF, then SPI_ADDR=11 data 0xA5. Stream base=5 len=1 must return 0xA5DEADBEEF.
- Wrap-around: stream base=2046 len=4 must read entries 2046, 2047, 0, 1 in that order.
- Back-pressure: stream len=6 with out_ready toggling 1,0,0,1,... Expect no lost or duplicated beats, at most 2 buffered, out_data stable while valid&&!ready.
- Contention: SPI commits on 3 consecutive cycles during a len=8 stream. Expect the stream stretched by 3 cycles and the correct 8 beats.
- Corner cases, one run each:
  - len=0 gives a done pulse with no beats.
  - Abort after 2 beats gives busy=0 and done on the next cycle, with no further valid.
  - rst mid-stream gives all outputs 0 on the next cycle.
